// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - mm:ss BCD countdown timer controller with start/pause/clear/alarm FSM
module countdown_timer_ctrl #(
   parameter int MAX_MIN   = 59,
   parameter int ALARM_SEC = 10
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en1hz,
   input  logic       i_btn_start,
   input  logic       i_btn_clr,
   input  logic       i_btn_min,
   input  logic       i_btn_sec,
   output logic [3:0] o_min10,
   output logic [3:0] o_min1,
   output logic [3:0] o_sec10,
   output logic [3:0] o_sec1,
   output logic       o_running,
   output logic       o_alarm,
   output logic       o_div_rst
);

   typedef enum logic [1:0] {
      S_STOP  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   localparam logic [3:0] MAX_T      = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_U      = 4'(MAX_MIN % 10);
   localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);

   state_t     r_state;
   logic [3:0] r_min10, r_min1, r_sec10, r_sec1;
   logic [5:0] r_alarm_cnt;
   logic       r_div_rst;

   logic [3:0] w_inc_min10, w_inc_min1;
   logic [3:0] w_inc_sec10, w_inc_sec1;
   logic [3:0] w_dec_min10, w_dec_min1, w_dec_sec10, w_dec_sec1;
   logic       w_nonzero;
   logic       w_dec_to_zero;

   assign w_nonzero     = (r_min10 != 4'd0) || (r_min1 != 4'd0) ||
                          (r_sec10 != 4'd0) || (r_sec1 != 4'd0);
   assign w_dec_to_zero = (r_min10 == 4'd0) && (r_min1 == 4'd0) &&
                          (r_sec10 == 4'd0) && (r_sec1 == 4'd1);

   // Setting increments: minutes wrap above MAX_MIN, seconds wrap 59 -> 00 without carry
   always_comb begin
      w_inc_min10 = r_min10;
      w_inc_min1  = r_min1;
      w_inc_sec10 = r_sec10;
      w_inc_sec1  = r_sec1;
      if ((r_min10 > MAX_T) || ((r_min10 == MAX_T) && (r_min1 >= MAX_U))) begin
         w_inc_min10 = 4'd0;
         w_inc_min1  = 4'd0;
      end else if (r_min1 == 4'd9) begin
         w_inc_min10 = r_min10 + 4'd1;
         w_inc_min1  = 4'd0;
      end else begin
         w_inc_min1  = r_min1 + 4'd1;
      end
      if ((r_sec10 == 4'd5) && (r_sec1 == 4'd9)) begin
         w_inc_sec10 = 4'd0;
         w_inc_sec1  = 4'd0;
      end else if (r_sec1 == 4'd9) begin
         w_inc_sec10 = r_sec10 + 4'd1;
         w_inc_sec1  = 4'd0;
      end else begin
         w_inc_sec1  = r_sec1 + 4'd1;
      end
   end

   // One-second BCD decrement with borrow through seconds into minutes
   always_comb begin
      w_dec_min10 = r_min10;
      w_dec_min1  = r_min1;
      w_dec_sec10 = r_sec10;
      w_dec_sec1  = r_sec1;
      if (r_sec1 != 4'd0) begin
         w_dec_sec1 = r_sec1 - 4'd1;
      end else if (r_sec10 != 4'd0) begin
         w_dec_sec10 = r_sec10 - 4'd1;
         w_dec_sec1  = 4'd9;
      end else begin
         w_dec_sec10 = 4'd5;
         w_dec_sec1  = 4'd9;
         if (r_min1 != 4'd0) begin
            w_dec_min1 = r_min1 - 4'd1;
         end else begin
            w_dec_min10 = r_min10 - 4'd1;
            w_dec_min1  = 4'd9;
         end
      end
   end

   // Control FSM: buttons prioritised CLR > START > MIN > SEC; DIV_RST marks the first RUN cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_STOP;
         r_min10     <= 4'd0;
         r_min1      <= 4'd0;
         r_sec10     <= 4'd0;
         r_sec1      <= 4'd0;
         r_alarm_cnt <= 6'd0;
         r_div_rst   <= 1'b0;
      end else begin
         r_div_rst <= 1'b0;
         if (i_btn_clr) begin
            r_state     <= S_STOP;
            r_min10     <= 4'd0;
            r_min1      <= 4'd0;
            r_sec10     <= 4'd0;
            r_sec1      <= 4'd0;
            r_alarm_cnt <= 6'd0;
         end else begin
            case (r_state)
               S_STOP: begin
                  if (i_btn_start) begin
                     if (w_nonzero) begin
                        r_state   <= S_RUN;
                        r_div_rst <= 1'b1;
                     end
                  end else if (i_btn_min) begin
                     r_min10 <= w_inc_min10;
                     r_min1  <= w_inc_min1;
                  end else if (i_btn_sec) begin
                     r_sec10 <= w_inc_sec10;
                     r_sec1  <= w_inc_sec1;
                  end
               end
               S_RUN: begin
                  if (i_btn_start) begin
                     r_state <= S_PAUSE;
                  end else if (i_en1hz && !r_div_rst) begin
                     r_min10 <= w_dec_min10;
                     r_min1  <= w_dec_min1;
                     r_sec10 <= w_dec_sec10;
                     r_sec1  <= w_dec_sec1;
                     if (w_dec_to_zero) begin
                        r_state     <= S_ALARM;
                        r_alarm_cnt <= 6'd0;
                     end
                  end
               end
               S_PAUSE: begin
                  if (i_btn_start) begin
                     r_state   <= S_RUN;
                     r_div_rst <= 1'b1;
                  end
               end
               S_ALARM: begin
                  r_min10 <= 4'd0;
                  r_min1  <= 4'd0;
                  r_sec10 <= 4'd0;
                  r_sec1  <= 4'd0;
                  if (i_btn_start) begin
                     r_state     <= S_STOP;
                     r_alarm_cnt <= 6'd0;
                  end else if (i_en1hz) begin
                     if (r_alarm_cnt >= ALARM_LAST) begin
                        r_state     <= S_STOP;
                        r_alarm_cnt <= 6'd0;
                     end else begin
                        r_alarm_cnt <= r_alarm_cnt + 6'd1;
                     end
                  end
               end
               default: begin
                  r_state <= S_STOP;
               end
            endcase
         end
      end
   end

   assign o_min10   = r_min10;
   assign o_min1    = r_min1;
   assign o_sec10   = r_sec10;
   assign o_sec1    = r_sec1;
   assign o_running = (r_state == S_RUN);
   assign o_alarm   = (r_state == S_ALARM);
   assign o_div_rst = r_div_rst;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - directed self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

   logic       clk;
   logic       rst;
   logic       en1hz, btn_start, btn_clr, btn_min, btn_sec;
   logic [3:0] min10, min1, sec10, sec1;
   logic       running, alarm, div_rst;
   logic [15:0] digits;

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer_ctrl #(.MAX_MIN(59), .ALARM_SEC(10)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en1hz     (en1hz),
      .i_btn_start (btn_start),
      .i_btn_clr   (btn_clr),
      .i_btn_min   (btn_min),
      .i_btn_sec   (btn_sec),
      .o_min10     (min10),
      .o_min1      (min1),
      .o_sec10     (sec10),
      .o_sec1      (sec1),
      .o_running   (running),
      .o_alarm     (alarm),
      .o_div_rst   (div_rst)
   );

   assign digits = {min10, min1, sec10, sec1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs from a negedge, return at the next negedge
   task automatic step(input logic st, input logic cl, input logic mn, input logic sc, input logic en);
      btn_start = st; btn_clr = cl; btn_min = mn; btn_sec = sc; en1hz = en;
      @(negedge clk);
      btn_start = 0; btn_clr = 0; btn_min = 0; btn_sec = 0; en1hz = 0;
   endtask

   task automatic test_reset;
      n_checks++;
      if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h expected 0000", digits); end
      n_checks++;
      if ({running, alarm, div_rst} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {running, alarm, div_rst}); end
   endtask

   task automatic test_set_and_start;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
      n_checks++;
      if (digits !== 16'h0203) begin n_fail++; $display("FAIL set_value: got %h expected 0203", digits); end
      step(1, 0, 0, 0, 0);
      n_checks++;
      if ({running, div_rst} !== 2'b11) begin n_fail++; $display("FAIL start_entry: got %b expected 11", {running, div_rst}); end
      step(0, 0, 0, 0, 0);
      n_checks++;
      if ({running, div_rst} !== 2'b10) begin n_fail++; $display("FAIL div_rst_one_cycle: got %b expected 10", {running, div_rst}); end
      n_checks++;
      if (digits !== 16'h0203) begin n_fail++; $display("FAIL run_hold: got %h expected 0203", digits); end
   endtask

   task automatic test_borrow;
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (digits !== 16'h0100) begin n_fail++; $display("FAIL first_run_tick_ignored: got %h expected 0100", digits); end
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (digits !== 16'h0059) begin n_fail++; $display("FAIL borrow_0100: got %h expected 0059", digits); end
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (digits !== 16'h0959) begin n_fail++; $display("FAIL borrow_1000: got %h expected 0959", digits); end
   endtask

   task automatic test_alarm;
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({digits, alarm} !== {16'h0001, 1'b0}) begin n_fail++; $display("FAIL tick_0002: got %h/%b expected 0001/0", digits, alarm); end
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({digits, running, alarm} !== {16'h0000, 2'b01}) begin n_fail++; $display("FAIL enter_alarm: got %h/%b expected 0000/01", digits, {running, alarm}); end
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);
      n_checks++;
      if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_after_9: got %b expected 1", alarm); end
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({running, alarm} !== 2'b00) begin n_fail++; $display("FAIL alarm_expire: got %b expected 00", {running, alarm}); end
      step(1, 0, 0, 0, 0);
      n_checks++;
      if (running !== 1'b0) begin n_fail++; $display("FAIL stop_at_zero_after_alarm: got %b expected 0", running); end
   endtask

   task automatic test_pause;
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (digits !== 16'h0104) begin n_fail++; $display("FAIL pre_pause_tick: got %h expected 0104", digits); end
      step(1, 0, 0, 0, 1);
      n_checks++;
      if ({digits, running, alarm} !== {16'h0104, 2'b00}) begin n_fail++; $display("FAIL pause_entry: got %h/%b expected 0104/00", digits, {running, alarm}); end
      step(0, 0, 1, 1, 1);
      n_checks++;
      if (digits !== 16'h0104) begin n_fail++; $display("FAIL pause_frozen: got %h expected 0104", digits); end
      step(1, 0, 0, 0, 0);
      n_checks++;
      if ({running, div_rst} !== 2'b11) begin n_fail++; $display("FAIL resume_div_rst: got %b expected 11", {running, div_rst}); end
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({digits, div_rst} !== {16'h0104, 1'b0}) begin n_fail++; $display("FAIL resume_first_tick: got %h/%b expected 0104/0", digits, div_rst); end
   endtask

   task automatic test_stop_rules;
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_checks++;
      if ({running, div_rst} !== 2'b00) begin n_fail++; $display("FAIL start_at_zero: got %b expected 00", {running, div_rst}); end
      step(0, 0, 1, 1, 0);
      n_checks++;
      if (digits !== 16'h0100) begin n_fail++; $display("FAIL min_over_sec: got %h expected 0100", digits); end
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
      n_checks++;
      if (digits !== 16'h5900) begin n_fail++; $display("FAIL min_max: got %h expected 5900", digits); end
      step(0, 0, 1, 0, 0);
      n_checks++;
      if (digits !== 16'h0000) begin n_fail++; $display("FAIL min_wrap: got %h expected 0000", digits); end
      for (int i = 0; i < 60; i++) step(0, 0, 0, 1, 0);
      n_checks++;
      if (digits !== 16'h0000) begin n_fail++; $display("FAIL sec_wrap: got %h expected 0000", digits); end
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      n_checks++;
      if ({digits, running, alarm} !== {16'h0000, 2'b00}) begin n_fail++; $display("FAIL clr_over_start: got %h/%b expected 0000/00", digits, {running, alarm}); end
   endtask

   task automatic test_async_reset;
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
      for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({digits, running} !== {16'h0517, 1'b1}) begin n_fail++; $display("FAIL pre_reset: got %h/%b expected 0517/1", digits, running); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({digits, running, alarm, div_rst} !== 19'd0) begin n_fail++; $display("FAIL async_reset: got %h/%b expected 0000/000", digits, {running, alarm, div_rst}); end
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0, 1);
      n_checks++;
      if ({digits, running, div_rst} !== 18'd0) begin n_fail++; $display("FAIL post_reset_stop: got %h/%b expected 0000/00", digits, {running, div_rst}); end
   endtask

   initial begin
      rst = 1'b1;
      en1hz = 0; btn_start = 0; btn_clr = 0; btn_min = 0; btn_sec = 0;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_set_and_start();
      test_borrow();
      test_alarm();
      test_pause();
      test_stop_rules();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
